// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode, flag-index and FSM-state definitions for alu_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_OP_AND = 3'd0;
    localparam logic [2:0] ALU_OP_ADD = 3'd1;
    localparam logic [2:0] ALU_OP_SUB = 3'd2;
    localparam logic [2:0] ALU_OP_OR  = 3'd3;
    localparam logic [2:0] ALU_OP_XOR = 3'd4;
    localparam logic [2:0] ALU_OP_SLL = 3'd5;
    localparam logic [2:0] ALU_OP_SRA = 3'd6;
    localparam logic [2:0] ALU_OP_MUL = 3'd7;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Request/result handshake bundle between EX issue and the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       ALUop;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Output;
    logic [3:0]       flags;

    modport master (
        output in_valid, A, B, ALUop, out_ready,
        input  in_ready, out_valid, Output, flags
    );

    modport slave (
        input  in_valid, A, B, ALUop, out_ready,
        output in_ready, out_valid, Output, flags
    );

endinterface
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Iterative shift-add signed multiplier, one bit per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               start,
    input  wire logic [WIDTH-1:0]   A,
    input  wire logic [WIDTH-1:0]   B,
    output logic                    done,
    output logic [2*WIDTH-1:0]      product
);

    localparam int CW = $clog2(WIDTH);

    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_ma;
    logic [WIDTH-1:0]   r_mb;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;

    // Unsigned magnitudes: the most negative operand maps to 2**(WIDTH-1), which fits.
    assign w_addend   = r_mb[r_cnt] ? ({{WIDTH{1'b0}}, r_ma} << r_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;
    assign done       = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign product    = r_neg ? (~w_acc_next + (2*WIDTH)'(1)) : w_acc_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_ma   <= '0;
            r_mb   <= '0;
            r_neg  <= 1'b0;
            r_acc  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_ma   <= A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
            r_mb   <= B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
            r_neg  <= A[WIDTH-1] ^ B[WIDTH-1];
            r_acc  <= '0;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            if (done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : EX-stage ALU with valid/ready handshake, flags and iterative MUL.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_pipe_if.slave   bus
);

    localparam int SHW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_output;
    logic [3:0]         r_flags;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic               w_mul_ovf;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_result;
    logic               w_carry;
    logic               w_ovf;
    logic               w_wr;
    logic [WIDTH-1:0]   w_wr_result;
    logic [3:0]         w_wr_flags;

    assign w_in_ready  = rst_n && (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_mul_start = w_accept && (bus.ALUop == ALU_OP_MUL);
    assign w_shamt     = bus.B[SHW-1:0];
    assign w_sum       = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_diff      = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        case (bus.ALUop)
            ALU_OP_AND: w_result = bus.A & bus.B;
            ALU_OP_ADD: begin
                w_result = w_sum[WIDTH-1:0];
                w_carry  = w_sum[WIDTH];
                w_ovf    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                w_result = w_diff[WIDTH-1:0];
                w_carry  = w_diff[WIDTH];
                w_ovf    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            ALU_OP_OR:  w_result = bus.A | bus.B;
            ALU_OP_XOR: w_result = bus.A ^ bus.B;
            ALU_OP_SLL: w_result = bus.A << w_shamt;
            ALU_OP_SRA: w_result = $signed(bus.A) >>> w_shamt;
            default:    w_result = '0;
        endcase
    end

    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .A       (bus.A),
        .B       (bus.B),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Overflow when the full product differs from the sign extension of its low half.
    assign w_mul_ovf = (w_product != {{WIDTH{w_product[WIDTH-1]}}, w_product[WIDTH-1:0]});

    assign w_wr        = (w_accept && !w_mul_start) || w_mul_done;
    assign w_wr_result = w_mul_done ? w_product[WIDTH-1:0] : w_result;

    always_comb begin
        w_wr_flags         = '0;
        w_wr_flags[FLAG_Z] = (w_wr_result == '0);
        w_wr_flags[FLAG_N] = w_wr_result[WIDTH-1];
        w_wr_flags[FLAG_C] = w_mul_done ? 1'b0 : w_carry;
        w_wr_flags[FLAG_V] = w_mul_done ? w_mul_ovf : w_ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // A fresh write wins over the consume-clear, giving one result per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_output    <= '0;
            r_flags     <= '0;
        end else if (w_wr) begin
            r_out_valid <= 1'b1;
            r_output    <= w_wr_result;
            r_flags     <= w_wr_flags;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.Output    = r_output;
    assign bus.flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Vector table plus scoreboard bench for alu_pipe at WIDTH=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int WIDTH = 16;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_out;
        logic [3:0]  exp_flags;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic [3:0]  fl;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;
    exp_t exp_q[$];
    vec_t vecs[19];

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Results are compared when the consumer actually takes them.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h/%b expected no result", bus.Output, bus.flags);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_output", 32'(bus.Output), 32'(e.out));
                chk("sb_flags", 32'(bus.flags), 32'(e.fl));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eo, input logic [3:0] ef);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready got 0 expected 1");
        end else begin
            bus.ALUop    = op;
            bus.A        = a;
            bus.B        = b;
            bus.in_valid = 1'b1;
            @(posedge clk);
            exp_q.push_back('{eo, ef});
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic busy_ok;
        logic hold_ok;
        logic stray;
        int   lat;

        n_vec  = 0;
        n_fail = 0;
        //            op    A         B         Output    {Z,N,C,V}
        vecs[0]  = '{3'd1, 16'd15,   16'hFFF6, 16'd5,    4'b0010};
        vecs[1]  = '{3'd1, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
        vecs[2]  = '{3'd2, 16'd30,   16'd30,   16'h0000, 4'b1010};
        vecs[3]  = '{3'd0, 16'd3,    16'd2,    16'h0002, 4'b0000};
        vecs[4]  = '{3'd4, 16'h00FF, 16'h0F0F, 16'h0FF0, 4'b0000};
        vecs[5]  = '{3'd6, 16'hFFF0, 16'd2,    16'hFFFC, 4'b0100};
        vecs[6]  = '{3'd5, 16'd1,    16'd15,   16'h8000, 4'b0100};
        vecs[7]  = '{3'd3, 16'h1200, 16'h0034, 16'h1234, 4'b0000};
        vecs[8]  = '{3'd2, 16'd5,    16'd7,    16'hFFFE, 4'b0100};
        vecs[9]  = '{3'd2, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
        vecs[10] = '{3'd5, 16'h0003, 16'h0011, 16'h0006, 4'b0000};
        vecs[11] = '{3'd1, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
        vecs[12] = '{3'd6, 16'h8000, 16'd15,   16'hFFFF, 4'b0100};
        vecs[13] = '{3'd7, 16'hFFEC, 16'd25,   16'hFE0C, 4'b0100};
        vecs[14] = '{3'd7, 16'd300,  16'd300,  16'h5F90, 4'b0001};
        vecs[15] = '{3'd7, 16'h8000, 16'h0001, 16'h8000, 4'b0100};
        vecs[16] = '{3'd7, 16'h8000, 16'h8000, 16'h0000, 4'b1001};
        vecs[17] = '{3'd7, 16'hFFFD, 16'hFFFB, 16'h000F, 4'b0000};
        vecs[18] = '{3'd7, 16'h0000, 16'd5,    16'h0000, 4'b1000};

        // Reset with a pending request
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ALUop     = 3'd1;
        bus.A         = 16'd1;
        bus.B         = 16'd1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready_1", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rst_output", 32'(bus.Output), 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready_2", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Table: single-cycle ops issue back-to-back, MULs wait for in_ready
        for (int i = 0; i < 19; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_flags);
        end
        drain();

        // MUL latency, in_ready low throughout, concurrent request ignored
        bus.ALUop = 3'd7; bus.A = 16'hFFEC; bus.B = 16'd25; bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back('{16'hFE0C, 4'b0100});
        #1;
        bus.ALUop = 3'd1; bus.A = 16'd1; bus.B = 16'd1;
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("mul_latency", 32'(lat), 32'd16);
        chk("mul_in_ready_busy", 32'(busy_ok), 32'd1);
        drain();

        // Back-pressure holds the result and blocks the next request
        bus.out_ready = 1'b0;
        bus.ALUop = 3'd1; bus.A = 16'd30; bus.B = 16'd30; bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back('{16'd60, 4'b0000});
        #1;
        bus.ALUop = 3'd2; bus.A = 16'd10; bus.B = 16'd3;
        hold_ok = 1'b1;
        repeat (5) begin
            if (bus.Output !== 16'd60 || bus.flags !== 4'b0000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("bp_hold", 32'(hold_ok), 32'd1);
        chk("bp_output_held", 32'(bus.Output), 32'd60);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back('{16'd7, 4'b0010});
        #1;
        bus.in_valid = 1'b0;
        chk("bp_second_out", 32'(bus.Output), 32'd7);
        chk("bp_second_valid", 32'(bus.out_valid), 32'd1);
        drain();

        // Reset during MUL discards it
        bus.ALUop = 3'd7; bus.A = 16'd7; bus.B = 16'd9; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mr_output", 32'(bus.Output), 32'd0);
        chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_flags", 32'(bus.flags), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mr_in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.ALUop = 3'd1; bus.A = 16'd1; bus.B = 16'd1; bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back('{16'd2, 4'b0000});
        #1;
        bus.in_valid = 1'b0;
        chk("mr_add_out", 32'(bus.Output), 32'd2);
        chk("mr_add_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;
        stray = 1'b0;
        repeat (20) begin
            if (bus.out_valid) stray = 1'b1;
            @(posedge clk); #1;
        end
        chk("mr_no_stray", 32'(stray), 32'd0);

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
